// File: rtl/cmac_pkg.sv
// Shared constants for the CMAC transmit path: output FSM encoding and
// DW-independent counter widths.
package cmac_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } tx_state_t;

    localparam int CNT_W    = 8;   // beat counter and ready-packet counter
    localparam int STAT_W   = 16;  // wrapping packet statistics
    localparam int PF_DEPTH = 2;   // output prefetch entries

endpackage

// File: rtl/cmac_xmit_sfwd_if.sv
// AXI-Stream style beat bus (no tkeep/tuser) used on both sides of the
// store-and-forward buffer.
interface cmac_xmit_sfwd_if #(
    parameter int DW = 512
) ();

    logic [DW-1:0] tdata;
    logic          tlast;
    logic          tvalid;
    logic          tready;

    modport master (output tdata, output tlast, output tvalid, input  tready);
    modport slave  (input  tdata, input  tlast, input  tvalid, output tready);

endinterface

// File: rtl/sfwd_ram.sv
// Simple dual-port packet buffer: one write port, one registered read port,
// written so synthesis maps it onto block or ultra RAM.
module sfwd_ram #(
    parameter  int DW    = 513,
    parameter  int DEPTH = 256,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    // NOTE: sequential state uses <= so every flop samples pre-edge values; the
    // array carries no reset, which would stop it mapping onto RAM primitives.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/cmac_xmit_sfwd.sv
// Store-and-forward packet buffer ahead of the CMAC tx port: packets leave only
// once wholly stored, oversize packets are dropped, output bursts are gap-free.
module cmac_xmit_sfwd
    import cmac_pkg::*;
#(
    parameter int DW        = 512,
    parameter int DEPTH     = 256,
    parameter int MAX_BEATS = 65
) (
    input  logic              clk,
    input  logic              reset,
    cmac_xmit_sfwd_if.slave   axis_in,
    cmac_xmit_sfwd_if.master  axis_out,
    output logic [STAT_W-1:0] pkts_sent,
    output logic [STAT_W-1:0] pkts_dropped
);

    localparam int AW = $clog2(DEPTH);
    localparam int FW = AW + 2;

    logic [AW-1:0]    wr_ptr, cm_ptr, rd_ptr, used;
    logic [CNT_W-1:0] rdy_cnt, beat_cnt;
    logic             discard, run;
    logic [1:0]       pf_vcnt, pf_slot;
    logic [2:0]       pf_rsv;
    logic             rd_pend, rd_en, pf_idx;
    logic [DW:0]      ram_q;
    logic [DW:0]      pf_q [PF_DEPTH];
    logic [FW-1:0]    free_w;
    logic             in_ready, in_fire, keep, wr_en, commit, drop;
    logic             out_valid, out_fire, start;
    tx_state_t        state, state_nx;

    // Prefetch slots (in flight + held) are reserved against buffer space.
    assign used     = wr_ptr - rd_ptr;
    assign pf_rsv   = {1'b0, pf_vcnt} + {2'b00, rd_pend};
    assign free_w   = FW'(DEPTH) - FW'(used) - FW'(pf_rsv);
    assign in_ready = run && !reset && (discard || (free_w != '0));
    assign in_fire  = axis_in.tvalid && in_ready;
    assign keep     = !discard && (beat_cnt < CNT_W'(MAX_BEATS));
    assign wr_en    = in_fire && keep;
    assign commit   = wr_en && axis_in.tlast;
    assign drop     = in_fire && !keep && axis_in.tlast;

    assign axis_in.tready = in_ready;

    sfwd_ram #(.DW(DW + 1), .DEPTH(DEPTH)) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata ({axis_in.tlast, axis_in.tdata}),
        .re    (rd_en),
        .raddr (rd_ptr),
        .rdata (ram_q)
    );

    // Only committed beats are fetched, so a rollback never touches prefetch.
    assign rd_en    = (rd_ptr != cm_ptr) && ((pf_rsv < 3'(PF_DEPTH)) || out_fire);
    assign out_fire = out_valid && axis_out.tready;
    assign pf_slot  = pf_vcnt - 2'(out_fire);
    assign pf_idx   = pf_slot[0];

    always_comb begin
        // NOTE: defaults first so no branch leaves a signal unassigned (no latches).
        state_nx  = state;
        start     = 1'b0;
        out_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rdy_cnt != '0) begin
                    state_nx = ST_SEND;
                    start    = 1'b1;
                end
            end
            ST_SEND: begin
                out_valid = (pf_vcnt != 2'd0) && !reset;
                if (out_valid && axis_out.tready && pf_q[0][DW]) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign axis_out.tvalid = out_valid;
    assign axis_out.tlast  = out_valid && pf_q[0][DW];
    assign axis_out.tdata  = pf_q[0][DW-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr       <= '0;
            cm_ptr       <= '0;
            rd_ptr       <= '0;
            rdy_cnt      <= '0;
            beat_cnt     <= '0;
            discard      <= 1'b0;
            run          <= 1'b0;
            pf_vcnt      <= '0;
            rd_pend      <= 1'b0;
            pkts_sent    <= '0;
            pkts_dropped <= '0;
            state        <= ST_IDLE;
        end else begin
            run   <= 1'b1;
            state <= state_nx;
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (commit) begin
                cm_ptr <= wr_ptr + AW'(1);
            end
            if (drop) begin
                wr_ptr       <= cm_ptr;
                pkts_dropped <= pkts_dropped + STAT_W'(1);
            end
            if (in_fire) begin
                if (axis_in.tlast) begin
                    beat_cnt <= '0;
                    discard  <= 1'b0;
                end else if (keep) begin
                    beat_cnt <= beat_cnt + CNT_W'(1);
                end else begin
                    discard  <= 1'b1;
                end
            end
            case ({commit, start})
                2'b10:   rdy_cnt <= rdy_cnt + CNT_W'(1);
                2'b01:   rdy_cnt <= rdy_cnt - CNT_W'(1);
                default: ;
            endcase
            rd_pend <= rd_en;
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            pf_vcnt <= pf_vcnt + 2'(rd_pend) - 2'(out_fire);
            if (out_fire && pf_q[0][DW]) begin
                pkts_sent <= pkts_sent + STAT_W'(1);
            end
        end
    end

    // Two-entry prefetch FIFO, head in slot 0; a returning read lands behind
    // whatever is still held after this cycle's pop.
    always_ff @(posedge clk) begin
        if (out_fire) begin
            pf_q[0] <= pf_q[1];
        end
        if (rd_pend) begin
            pf_q[pf_idx] <= ram_q;
        end
    end

endmodule

// File: tb/tb_cmac_xmit_sfwd.sv
// Self-checking bench for cmac_xmit_sfwd: legal beats go into a scoreboard
// queue as they are driven and are compared as the DUT emits them.
module tb_cmac_xmit_sfwd;

    localparam int DW        = 64;
    localparam int DEPTH     = 256;
    localparam int MAX_BEATS = 65;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] pkts_sent, pkts_dropped;

    int    checks   = 0;
    int    failures = 0;
    int    beats_in = 0;
    int    out_mode = 0;  // 0: stall, 1: always ready, 2: random 50%
    beat_t exp_q[$];

    always #5 clk = ~clk;

    cmac_xmit_sfwd_if #(.DW(DW)) in_if ();
    cmac_xmit_sfwd_if #(.DW(DW)) out_if ();

    cmac_xmit_sfwd #(.DW(DW), .DEPTH(DEPTH), .MAX_BEATS(MAX_BEATS)) dut (
        .clk          (clk),
        .reset        (reset),
        .axis_in      (in_if),
        .axis_out     (out_if),
        .pkts_sent    (pkts_sent),
        .pkts_dropped (pkts_dropped)
    );

    initial begin
        out_if.tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (out_mode)
                0:       out_if.tready = 1'b0;
                1:       out_if.tready = 1'b1;
                default: out_if.tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        in_if.tvalid = 1'b0;
        in_if.tlast  = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        align();
    endtask

    task automatic send_pkt(input int len, input int gap_max, input bit legal);
        beat_t b;
        int    gaps, waitc;
        bit    acc;
        for (int i = 0; i < len; i++) begin
            gaps = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
            in_if.tvalid = 1'b0;
            repeat (gaps) align();
            b.data = {$urandom, $urandom};
            b.last = (i == len - 1);
            in_if.tvalid = 1'b1;
            in_if.tdata  = b.data;
            in_if.tlast  = b.last;
            if (legal) exp_q.push_back(b);
            acc   = 1'b0;
            waitc = 0;
            while (!acc) begin
                @(negedge clk);
                acc = (in_if.tready === 1'b1);
                align();
                if (!acc && ++waitc > 4000) begin
                    checks++;
                    failures++;
                    $display("FAIL in_accept_timeout beat=%0d waited=%0d cycles", i, waitc);
                    in_if.tvalid = 1'b0;
                    return;
                end
            end
            beats_in++;
        end
        in_if.tvalid = 1'b0;
        in_if.tlast  = 1'b0;
    endtask

    task automatic collect(input int n_pkts, input int budget, input string tag);
        int            got, cyc;
        logic          pv, pr, pl;
        logic [DW-1:0] pd;
        beat_t         e;
        got = 0; cyc = 0; pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0;
        while (got < n_pkts) begin
            @(negedge clk);
            if (++cyc > budget) begin
                checks++;
                failures++;
                $display("FAIL %s_timeout packets got=%0d expected=%0d", tag, got, n_pkts);
                break;
            end
            if (pv && !pr) begin
                checks++;
                if (out_if.tvalid !== 1'b1 || out_if.tdata !== pd || out_if.tlast !== pl) begin
                    failures++;
                    $display("FAIL %s_stall_hold valid=%b data=%h last=%b expected valid=1 data=%h last=%b",
                             tag, out_if.tvalid, out_if.tdata, out_if.tlast, pd, pl);
                end
            end else if (pv && pr && !pl) begin
                checks++;
                if (out_if.tvalid !== 1'b1) begin
                    failures++;
                    $display("FAIL %s_in_packet_gap valid=%b expected=1", tag, out_if.tvalid);
                end
            end
            if (out_if.tvalid === 1'b1 && out_if.tready === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL %s_unexpected_beat data=%h last=%b expected none", tag,
                             out_if.tdata, out_if.tlast);
                end else begin
                    e = exp_q.pop_front();
                    if (out_if.tdata !== e.data || out_if.tlast !== e.last) begin
                        failures++;
                        $display("FAIL %s_beat data=%h last=%b expected data=%h last=%b", tag,
                                 out_if.tdata, out_if.tlast, e.data, e.last);
                    end
                end
                if (out_if.tlast === 1'b1) got++;
            end
            pv = out_if.tvalid; pr = out_if.tready; pd = out_if.tdata; pl = out_if.tlast;
        end
    endtask

    task automatic check_counts(input string tag, input int sent, input int dropped);
        checks++;
        if (pkts_sent !== 16'(sent) || pkts_dropped !== 16'(dropped) || exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_counts sent=%0d dropped=%0d left=%0d expected sent=%0d dropped=%0d left=0",
                     tag, pkts_sent, pkts_dropped, exp_q.size(), sent, dropped);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_if.tvalid !== 1'b0 || out_if.tlast !== 1'b0 || in_if.tready !== 1'b0) begin
            failures++;
            $display("FAIL reset_during valid=%b last=%b in_ready=%b expected 0 0 0",
                     out_if.tvalid, out_if.tlast, in_if.tready);
        end
        align();
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (out_if.tvalid !== 1'b0 || out_if.tlast !== 1'b0 || in_if.tready !== 1'b0 ||
            pkts_sent !== 16'd0 || pkts_dropped !== 16'd0) begin
            failures++;
            $display("FAIL reset_after valid=%b last=%b in_ready=%b sent=%0d dropped=%0d expected all 0",
                     out_if.tvalid, out_if.tlast, in_if.tready, pkts_sent, pkts_dropped);
        end
        @(negedge clk);
        checks++;
        if (in_if.tready !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready_return in_ready=%b expected=1", in_if.tready);
        end
        align();
    endtask

    task automatic test_store_forward();
        bit early;
        do_reset();
        out_mode = 1;
        beats_in = 0;
        early    = 1'b0;
        fork
            send_pkt(10, 4, 1'b1);
            begin
                for (int c = 0; c < 1000 && beats_in < 10; c++) begin
                    @(negedge clk);
                    if (out_if.tvalid === 1'b1) early = 1'b1;
                end
                checks++;
                if (early) begin
                    failures++;
                    $display("FAIL store_early_output valid seen=1 expected=0 before tlast stored");
                end
                collect(1, 500, "store");
            end
        join
        align();
        check_counts("store", 1, 0);
    endtask

    task automatic test_max_packet();
        do_reset();
        out_mode = 1;
        fork
            send_pkt(MAX_BEATS, 3, 1'b1);
            collect(1, 3000, "max_pkt");
        join
        align();
        check_counts("max_pkt", 1, 0);
    endtask

    task automatic test_oversize_drop();
        do_reset();
        out_mode = 1;
        fork
            begin
                send_pkt(70, 0, 1'b0);
                send_pkt(2, 1, 1'b1);
            end
            collect(1, 2000, "drop70");
        join
        align();
        check_counts("drop70", 1, 1);
        fork
            begin
                send_pkt(MAX_BEATS + 1, 0, 1'b0);
                send_pkt(1, 0, 1'b1);
            end
            collect(1, 2000, "drop66");
        join
        align();
        check_counts("drop66", 2, 2);
    endtask

    task automatic test_stall_toggle();
        do_reset();
        out_mode = 0;
        send_pkt(1, 0, 1'b1);
        send_pkt(2, 0, 1'b1);
        send_pkt(MAX_BEATS, 0, 1'b1);
        out_mode = 2;
        collect(3, 5000, "toggle");
        align();
        check_counts("toggle", 3, 0);
    endtask

    task automatic test_fill();
        do_reset();
        out_mode = 0;
        beats_in = 0;
        fork
            repeat (4) send_pkt(MAX_BEATS, 0, 1'b1);
            begin
                for (int c = 0; c < 3000 && beats_in < 256; c++) @(negedge clk);
                repeat (10) @(negedge clk);
                checks++;
                if (beats_in != 256 || in_if.tready !== 1'b0) begin
                    failures++;
                    $display("FAIL fill_backpressure accepted=%0d in_ready=%b expected 256 and 0",
                             beats_in, in_if.tready);
                end
                out_mode = 1;
                collect(4, 5000, "fill");
            end
        join
        align();
        check_counts("fill", 4, 0);
    endtask

    task automatic test_reset_mid_packet();
        beat_t e;
        int    n;
        do_reset();
        out_mode = 0;
        send_pkt(MAX_BEATS, 0, 1'b1);
        out_mode = 1;
        n = 0;
        for (int c = 0; c < 1000 && n < 29; c++) begin
            @(negedge clk);
            if (out_if.tvalid === 1'b1 && out_if.tready === 1'b1 && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n++;
                checks++;
                if (out_if.tdata !== e.data) begin
                    failures++;
                    $display("FAIL midrst_beat data=%h expected=%h", out_if.tdata, e.data);
                end
            end
        end
        align();
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (out_if.tvalid !== 1'b0 || in_if.tready !== 1'b0) begin
            failures++;
            $display("FAIL midrst_during valid=%b in_ready=%b expected 0 0", out_if.tvalid, in_if.tready);
        end
        align();
        reset = 1'b0;
        exp_q.delete();
        @(negedge clk);
        checks++;
        if (out_if.tvalid !== 1'b0 || out_if.tlast !== 1'b0 || pkts_sent !== 16'd0 ||
            pkts_dropped !== 16'd0) begin
            failures++;
            $display("FAIL midrst_after valid=%b last=%b sent=%0d dropped=%0d expected all 0",
                     out_if.tvalid, out_if.tlast, pkts_sent, pkts_dropped);
        end
        align();
        fork
            send_pkt(2, 0, 1'b1);
            collect(1, 500, "midrst");
        join
        align();
        check_counts("midrst", 1, 0);
    endtask

    task automatic test_commit_on_start();
        bit extra;
        do_reset();
        out_mode = 1;
        fork
            begin
                send_pkt(1, 0, 1'b1);
                send_pkt(1, 0, 1'b1);
            end
            collect(2, 500, "commit_start");
        join
        extra = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (out_if.tvalid === 1'b1) extra = 1'b1;
        end
        checks++;
        if (extra) begin
            failures++;
            $display("FAIL commit_start_extra_output valid seen=1 expected=0");
        end
        align();
        check_counts("commit_start", 2, 0);
    endtask

    initial begin
        reset        = 1'b1;
        in_if.tvalid = 1'b0;
        in_if.tlast  = 1'b0;
        in_if.tdata  = '0;
        test_reset();
        test_store_forward();
        test_max_packet();
        test_oversize_drop();
        test_stall_toggle();
        test_fill();
        test_reset_mid_packet();
        test_commit_on_start();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout sim time exceeded expected completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
